// File: rtl/sram_pkg.sv
// Shared definitions for the frame-buffer SRAM: bus widths and arbiter state encoding.
// Reused by the display fetch and renderer blocks that talk to the arbiter.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned STARVE_W    = 4;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd1  = 3'd1,
        StRd2  = 3'd2,
        StWr1  = 3'd3,
        StWr2  = 3'd4,
        StWr3  = 3'd5
    } sram_state_e;

endpackage

// File: rtl/sram_arbiter.sv
// Arbiter and access sequencer for the external async frame SRAM. Reads have priority;
// a starvation counter forces a write through after STARVE_MAX back-to-back reads.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   rd_req,
    input  logic [SRAM_ADDR_W-1:0] rd_addr,
    output logic                   rd_ack,
    output logic [SRAM_DATA_W-1:0] rd_data,
    output logic                   rd_valid,

    input  logic                   wr_req,
    input  logic [SRAM_ADDR_W-1:0] wr_addr,
    input  logic [SRAM_DATA_W-1:0] wr_data,
    output logic                   wr_ack,

    output logic [SRAM_ADDR_W-1:0] sram_addr,
    inout  wire  [SRAM_DATA_W-1:0] sram_dq,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    sram_state_e            state_q, state_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
    logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;
    logic [STARVE_W-1:0]    starve_q, starve_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic                   bytes_n_q, bytes_n_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   rd_ack_q, rd_ack_d;
    logic                   wr_ack_q, wr_ack_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   write_win;

    // Write wins only when reads have starved it long enough or no read is pending.
    assign write_win = wr_req && ((starve_q == STARVE_LIM) || !rd_req);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        starve_d   = starve_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        bytes_n_d  = bytes_n_q;
        dq_oe_d    = dq_oe_q;
        rd_ack_d   = 1'b0;
        wr_ack_d   = 1'b0;
        rd_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!wr_req) begin
                    starve_d = '0;
                end
                if (write_win) begin
                    state_d   = StWr1;
                    addr_d    = wr_addr;
                    wdata_d   = wr_data;
                    ce_n_d    = 1'b0;
                    oe_n_d    = 1'b1;
                    bytes_n_d = 1'b0;
                    dq_oe_d   = 1'b1;
                    wr_ack_d  = 1'b1;
                    starve_d  = '0;
                end else if (rd_req) begin
                    state_d   = StRd1;
                    addr_d    = rd_addr;
                    ce_n_d    = 1'b0;
                    oe_n_d    = 1'b0;
                    bytes_n_d = 1'b0;
                    rd_ack_d  = 1'b1;
                    if (wr_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            StRd1: begin
                state_d = StRd2;
            end
            StRd2: begin
                state_d    = StIdle;
                rdata_d    = sram_dq;
                rd_valid_d = 1'b1;
                ce_n_d     = 1'b1;
                oe_n_d     = 1'b1;
                bytes_n_d  = 1'b1;
            end
            StWr1: begin
                state_d = StWr2;
                we_n_d  = 1'b0;
            end
            StWr2: begin
                state_d = StWr3;
                we_n_d  = 1'b1;
            end
            StWr3: begin
                state_d   = StIdle;
                ce_n_d    = 1'b1;
                bytes_n_d = 1'b1;
                dq_oe_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            starve_q   <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            bytes_n_q  <= 1'b1;
            dq_oe_q    <= 1'b0;
            rd_ack_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            starve_q   <= starve_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            bytes_n_q  <= bytes_n_d;
            dq_oe_q    <= dq_oe_d;
            rd_ack_q   <= rd_ack_d;
            wr_ack_q   <= wr_ack_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Bus enable is its own flop so the pad driver never sees a state-decode glitch.
    assign sram_dq   = dq_oe_q ? wdata_q : {SRAM_DATA_W{1'bz}};

    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = bytes_n_q;
    assign sram_lb_n = bytes_n_q;
    assign rd_ack    = rd_ack_q;
    assign wr_ack    = wr_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM on the shared bus.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [17:0] rd_addr = '0;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_req = 1'b0;
    logic [17:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:262143];

    sram_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

    always #10 clk = ~clk;

    // Async SRAM: drives the bus while selected and output-enabled, latches on we_n rise.
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge sram_we_n) begin
        if (!sram_ce_n) mem[sram_addr] = sram_dq;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [17:0] a, input logic [15:0] exp);
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        check_eq("rd_ack_hi", 32'(rd_ack), 32'd1);
        check_eq("rd_oe_n_lo1", 32'(sram_oe_n), 32'd0);
        check_eq("rd_ce_n_lo", 32'(sram_ce_n), 32'd0);
        check_eq("rd_we_n_hi", 32'(sram_we_n), 32'd1);
        check_eq("rd_addr_out", 32'(sram_addr), 32'(a));
        check_eq("rd_bus", 32'(sram_dq), 32'(exp));
        rd_req = 1'b0;
        @(negedge clk);
        check_eq("rd_ack_lo", 32'(rd_ack), 32'd0);
        check_eq("rd_oe_n_lo2", 32'(sram_oe_n), 32'd0);
        check_eq("rd_valid_early", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check_eq("rd_valid_hi", 32'(rd_valid), 32'd1);
        check_eq("rd_data", 32'(rd_data), 32'(exp));
        check_eq("rd_oe_n_off", 32'(sram_oe_n), 32'd1);
        check_eq("rd_ce_n_off", 32'(sram_ce_n), 32'd1);
        @(negedge clk);
        check_eq("rd_valid_lo", 32'(rd_valid), 32'd0);
        check_eq("rd_data_hold", 32'(rd_data), 32'(exp));
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        check_eq("wr_ack_hi", 32'(wr_ack), 32'd1);
        check_eq("wr1_we_n", 32'(sram_we_n), 32'd1);
        check_eq("wr1_oe_n", 32'(sram_oe_n), 32'd1);
        check_eq("wr1_ce_n", 32'(sram_ce_n), 32'd0);
        check_eq("wr1_addr", 32'(sram_addr), 32'(a));
        check_eq("wr1_dq", 32'(sram_dq), 32'(d));
        wr_req = 1'b0;
        @(negedge clk);
        check_eq("wr_ack_lo", 32'(wr_ack), 32'd0);
        check_eq("wr2_we_n", 32'(sram_we_n), 32'd0);
        check_eq("wr2_dq", 32'(sram_dq), 32'(d));
        @(negedge clk);
        check_eq("wr3_we_n", 32'(sram_we_n), 32'd1);
        check_eq("wr3_ce_n", 32'(sram_ce_n), 32'd0);
        check_eq("wr3_dq", 32'(sram_dq), 32'(d));
        @(negedge clk);
        check_eq("wr_done_ce_n", 32'(sram_ce_n), 32'd1);
        check_eq("wr_mem", 32'(mem[a]), 32'(d));
    endtask

    initial begin
        logic is_w [10];
        int   g;

        mem[18'h00123] = 16'hBEEF;
        repeat (2) @(negedge clk);
        check_eq("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check_eq("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
        check_eq("rst_ub_lb", {30'd0, sram_ub_n, sram_lb_n}, 32'd3);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("rst_acks", {29'd0, rd_ack, wr_ack, rd_valid}, 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_read(18'h00123, 16'hBEEF);
        do_write(18'h3FFFF, 16'h0034);
        do_read(18'h3FFFF, 16'h0034);
        // Data register now holds a non-zero word; a stray bus driver would corrupt this.
        do_read(18'h00123, 16'hBEEF);

        // Simultaneous requests with an empty starvation count: read first, write next.
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 18'h00123;
        wr_req  = 1'b1;
        wr_addr = 18'h00200;
        wr_data = 16'h1234;
        @(negedge clk);
        check_eq("sim_rd_first", 32'(rd_ack), 32'd1);
        check_eq("sim_wr_wait", 32'(wr_ack), 32'd0);
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("sim_wr_next", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("sim_wr_mem", 32'(mem[18'h00200]), 32'h1234);

        // Continuous load on both ports: R,R,R,R,W repeating.
        @(negedge clk);
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 18'h00300;
        wr_data = 16'h7777;
        g = 0;
        for (int c = 0; c < 200 && g < 10; c++) begin
            @(negedge clk);
            check_eq("oe_we_excl", 32'(!sram_oe_n && !sram_we_n), 32'd0);
            if (rd_ack || wr_ack) begin
                check_eq("ack_excl", 32'(rd_ack && wr_ack), 32'd0);
                is_w[g] = wr_ack;
                g++;
            end
        end
        check_eq("grant_count", 32'(g), 32'd10);
        for (int i = 0; i < g; i++) begin
            check_eq($sformatf("grant_%0d", i), 32'(is_w[i]), 32'((i % 5) == 4));
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (6) @(negedge clk);

        // Reset in the middle of WR2.
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = 18'h00077;
        wr_data = 16'h5555;
        @(negedge clk);
        wr_req = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        check_eq("mid_rst_ce_n", 32'(sram_ce_n), 32'd1);
        check_eq("mid_rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_eq("mid_rst_acks", {29'd0, rd_ack, wr_ack, rd_valid}, 32'd0);
        check_eq("mid_rst_addr", 32'(sram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_write(18'h00055, 16'hA5A5);
        do_read(18'h00055, 16'hA5A5);
        do_read(18'h00123, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Arbiter and access sequencer for the single external 256k×16 asynchronous SRAM that holds the frame image. Shares the chip between the display read port (VGA line fetch, priority) and the renderer write port (playfield drawing). Generates all SRAM control strobes and owns the bidirectional data bus. A starvation counter guarantees write progress under continuous read load.

## Interface
- STARVE_MAX, 4: consecutive read grants tolerated while a write is pending (1..15)
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-high reset
- rd_req  in  1  display requests a read; held with rd_addr until rd_ack
- rd_addr  in  18  read word address
- rd_ack  out  1  one-cycle pulse: read accepted, rd_addr may change next cycle
- rd_data  out  16  read result, held until next rd_valid
- rd_valid  out  1  one-cycle pulse: rd_data updated
- wr_req  in  1  renderer requests a write; held with wr_addr/wr_data until wr_ack
- wr_addr  in  18  write word address
- wr_data  in  16  write data
- wr_ack  out  1  one-cycle pulse: write accepted
- sram_addr  out  18  SRAM address, registered
- sram_dq  inout  16  SRAM data bus
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low, registered

## Operation
- States: IDLE, RD1, RD2, WR1, WR2, WR3.
- IDLE: if wr_req and (starve_cnt == STARVE_MAX or !rd_req) → WR1; else if rd_req → RD1; else stay.
- IDLE→RD1: sram_addr ← rd_addr, ce_n/oe_n/ub_n/lb_n ← 0, rd_ack ← 1. RD1→RD2 unconditional. RD2→IDLE: rd_data ← sram_dq, rd_valid ← 1, oe_n/ce_n ← 1.
- IDLE→WR1: sram_addr ← wr_addr, data register ← wr_data, ce_n/ub_n/lb_n ← 0, oe_n=1, wr_ack ← 1. WR1→WR2: we_n ← 0. WR2→WR3: we_n ← 1. WR3→IDLE: ce_n ← 1.
- sram_dq driven only in WR1, WR2, WR3; high-Z otherwise. oe_n and we_n never both low.
- starve_cnt (4 bit): +1 on each read grant while wr_req high (saturates at STARVE_MAX); cleared on write grant or when wr_req low in IDLE.
- Both requests in IDLE, starve_cnt < STARVE_MAX: read wins.
- Requests are sampled only in IDLE; req held through RD1/RD2/WR1–WR3 is not re-accepted until IDLE.
- Reset (asynchronous, any state): state IDLE; sram_addr 0; ce_n, oe_n, we_n, ub_n, lb_n all 1; sram_dq high-Z; rd_ack, wr_ack, rd_valid 0; rd_data 0; starve_cnt 0. A write interrupted by reset leaves that word's content undefined; no other word is affected.

## Timing
- Read: request sampled at edge E0 (IDLE); rd_ack high during cycle E0–E1; rd_valid high during cycle E2–E3. Occupancy 3 cycles (IDLE+RD1+RD2) → max read rate 1 per 3 cycles.
- Write: wr_ack high in WR1; we_n low exactly one cycle (WR2, 20 ns); address and data stable one cycle before and after we_n low. Occupancy 4 cycles.
- Requester may change req/addr/data at the edge ending the ack cycle.
- All strobes are flop outputs; no combinational path from inputs to SRAM pins.

## Structure
- Shared package sram_pkg: SRAM_ADDR_W = 18, SRAM_DATA_W = 16, state encoding constants; reused by display fetch and renderer.
- Single module; no sub-module. Tri-state buffer is a continuous assign in this module.

## Test plan
- rd_req=1, rd_addr=18'h00123, SRAM model returns 16'hBEEF → rd_ack 1 cycle, rd_valid 2 cycles later, rd_data=16'hBEEF, oe_n low 2 cycles, dq high-Z.
- wr_req=1, wr_addr=18'h3FFFF, wr_data=16'h0034 → wr_ack 1 cycle, we_n low exactly 1 cycle, dq=16'h0034 across WR1–WR3, model word 18'h3FFFF = 16'h0034.
- rd_req and wr_req both held high continuously, STARVE_MAX=4 → grant sequence R,R,R,R,W repeating; no write waits more than 4 reads.
- Simultaneous rd_req/wr_req from idle with starve_cnt=0 → read granted first, write granted in next IDLE.
- rst asserted mid-WR2 → same cycle we_n=1, ce_n=1, dq high-Z, acks/rd_valid 0; after release state IDLE, next wr_req completes normally.
